sipo_word_receiver: RTL and testbench

Serial-in, parallel-out receiver: the receive-side counterpart of the cube's PISO transmit shifter. It samples a serial bit stream MSB-first on qualified `shift` strobes and assembles WIDTH-bit words. Each completed word is presented on a single-entry valid/ready output register. It is used for loopback checking of the LED-driver shift chain and for inbound serial data from daisy-chained boards.

---
 rtl/cube_pkg.sv | 8 +
 rtl/sipo_word_receiver_shift_core.sv | 34 +++
 rtl/sipo_word_receiver.sv | 51 +++++
 tb/tb_sipo_word_receiver.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: shared cube shift-chain width, counter-width helper and output FSM states
package cube_pkg;
  localparam int CUBE_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
endpackage

// File: rtl/sipo_word_receiver_shift_core.sv
// sipo_shift_core: MSB-first partial-word assembler with frame resync
// ports: clk, reset_n (async, active-low); ser_in sampled on shift; frame_sync restarts the word;
//        word_done pulses with word holding the completed word; bit_count is the fill level.
module sipo_shift_core
  import cube_pkg::*;
#(
  parameter int WIDTH = CUBE_WIDTH,
  parameter int CW = cnt_w(WIDTH)
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_in,
  input  logic             shift,
  input  logic             frame_sync,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    bit_count
);
  logic [WIDTH-2:0] partial;
  assign word      = {partial, ser_in};
  assign word_done = shift && !frame_sync && bit_count == CW'(WIDTH-1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      partial   <= '0;
      bit_count <= '0;
    end else if (frame_sync) begin
      partial   <= (WIDTH-1)'(shift & ser_in);
      bit_count <= CW'(shift);
    end else if (shift) begin
      partial   <= word_done ? '0 : word[WIDTH-2:0];
      bit_count <= word_done ? '0 : bit_count + CW'(1);
    end
  end
endmodule

// File: rtl/sipo_word_receiver.sv
// sipo_word_receiver: serial-in parallel-out word receiver with single-entry valid/ready output
// ports: clk, reset_n (async, active-low); ser_in/shift/frame_sync drive the shift core;
//        par_out/out_valid/out_ready form the output handshake; overflow is a sticky
//        dropped-word flag cleared by overflow_clr; bit_count is the partial-word fill level.
module sipo_word_receiver
  import cube_pkg::*;
#(
  parameter int WIDTH = CUBE_WIDTH,
  parameter int CW = cnt_w(WIDTH)
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_in,
  input  logic             shift,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [CW-1:0]    bit_count
);
  out_state_e       state;
  logic             word_done;
  logic             drop;
  logic [WIDTH-1:0] word;
  sipo_shift_core #(.WIDTH(WIDTH), .CW(CW)) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .ser_in     (ser_in),
    .shift      (shift),
    .frame_sync (frame_sync),
    .word_done  (word_done),
    .word       (word),
    .bit_count  (bit_count)
  );
  assign out_valid = state == OUT_FULL;
  // a completed word is lost only if the held one is not being consumed on the same edge
  assign drop = word_done && state == OUT_FULL && !out_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= OUT_EMPTY;
      par_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (word_done && !drop) par_out <= word;
      state    <= word_done ? OUT_FULL : (out_ready ? OUT_EMPTY : state);
      overflow <= drop | (overflow & ~overflow_clr);
    end
  end
endmodule

// File: tb/tb_sipo_word_receiver.sv
// tb_sipo_word_receiver: table-driven and sequence checks of sipo_word_receiver
module tb_sipo_word_receiver;
  typedef struct {
    logic       ser_in;
    logic       shift;
    logic       frame_sync;
    logic       out_ready;
    logic       overflow_clr;
    logic [7:0] exp_par;
    logic       exp_valid;
    logic       exp_ovf;
    logic [2:0] exp_cnt;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_in = 1'b0;
  logic       shift = 1'b0;
  logic       frame_sync = 1'b0;
  logic       out_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] par_out;
  logic       out_valid;
  logic       overflow;
  logic [2:0] bit_count;
  int         tests = 0;
  int         fails = 0;
  vec_t       vecs[$];
  sipo_word_receiver #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ser_in       (ser_in),
    .shift        (shift),
    .frame_sync   (frame_sync),
    .par_out      (par_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .bit_count    (bit_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all(input string tag, input logic [7:0] p, input logic v, input logic o, input logic [2:0] c);
    check({tag, " par_out"}, 32'(par_out), 32'(p));
    check({tag, " out_valid"}, 32'(out_valid), 32'(v));
    check({tag, " overflow"}, 32'(overflow), 32'(o));
    check({tag, " bit_count"}, 32'(bit_count), 32'(c));
  endtask
  task automatic push(input logic si, input logic sh, input logic fs, input logic rdy, input logic clr,
                      input logic [7:0] p, input logic v, input logic o, input logic [2:0] c);
    vec_t t;
    t.ser_in = si; t.shift = sh; t.frame_sync = fs; t.out_ready = rdy; t.overflow_clr = clr;
    t.exp_par = p; t.exp_valid = v; t.exp_ovf = o; t.exp_cnt = c;
    vecs.push_back(t);
  endtask
  task automatic push_bits(input logic [7:0] w, input int n, input int start,
                           input logic [7:0] p, input logic v, input logic o);
    for (int i = 0; i < n; i++) push(w[7-i], 1'b1, 1'b0, 1'b0, 1'b0, p, v, o, 3'(start + i + 1));
  endtask
  task automatic step_bit(input logic b);
    ser_in = b;
    shift = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] w;
    logic [7:0] piso;
    push_bits(8'hA5, 7, 0, 8'h00, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd0);
    push_bits(8'h3C, 7, 0, 8'hA5, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd0);
    push_bits(8'hA5, 7, 0, 8'hA5, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd0);
    push_bits(8'h3C, 7, 0, 8'hA5, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 3'd0);
    push_bits(8'hFF, 3, 0, 8'h3C, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 3'd1);
    push_bits(8'hC0, 6, 1, 8'h3C, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h61, 1'b1, 1'b0, 3'd0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h61, 1'b1, 1'b0, 3'd0);
    push_bits(8'hFF, 7, 0, 8'h61, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h61, 1'b1, 1'b0, 3'd7);
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h61, 1'b1, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 3'd0);
    reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      ser_in = vecs[i].ser_in;
      shift = vecs[i].shift;
      frame_sync = vecs[i].frame_sync;
      out_ready = vecs[i].out_ready;
      overflow_clr = vecs[i].overflow_clr;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_par, vecs[i].exp_valid, vecs[i].exp_ovf, vecs[i].exp_cnt);
    end
    frame_sync = 1'b0;
    overflow_clr = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step_bit(1'b1);
    check("pre-reset bit_count", 32'(bit_count), 32'd5);
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #2;
    check_all("async reset", 8'h00, 1'b0, 1'b0, 3'd0);
    shift = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    w = 8'h81;
    for (int i = 0; i < 8; i++) step_bit(w[7-i]);
    check_all("post-reset 81", 8'h81, 1'b1, 1'b0, 3'd0);
    out_ready = 1'b1;
    piso = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      step_bit(piso[7]);
      piso = piso << 1;
    end
    check_all("loopback 5A", 8'h5A, 1'b1, 1'b0, 3'd0);
    for (int n = 0; n < 20; n++) begin
      w = 8'($urandom);
      for (int i = 0; i < 8; i++) step_bit(w[7-i]);
      check($sformatf("rand%0d par_out", n), 32'(par_out), 32'(w));
      check($sformatf("rand%0d out_valid", n), 32'(out_valid), 32'd1);
    end
    check("rand overflow", 32'(overflow), 32'd0);
    shift = 1'b0;
    @(posedge clk);
    #1;
    check("drain out_valid", 32'(out_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
